projectile_scheduler: RTL and testbench
=======================================

// Module: projectile_scheduler
// PURPOSE
// - Owns the pool of projectile slots for player and alien shots: accepts fire requests, allocates slots,
//   advances every live projectile once per frame, retires slots on hit or off-screen.
// - Sits between the player/alien control logic and the per-slot projectile_object drawers.
//   Per-slot active/proj_x/proj_y outputs feed those drawers directly.
// - Slot 0 is reserved for the player shot (one at a time); slots 1..NUM_SLOTS-1 hold alien shots.
// PARAMETERS
// NUM_SLOTS      4    total slots, 2..8; slot 0 = player
// PLAYER_SPEED   8    pixels/frame a player shot moves up
// ALIEN_SPEED    4    pixels/frame an alien shot moves down
// PLAYER_X_OFS   14   proj_x = player_x + PLAYER_X_OFS at launch
// PLAYER_Y_OFS   8    proj_y = player_y - PLAYER_Y_OFS at launch
// TOP_LIMIT      0    a shot whose new y < TOP_LIMIT is retired
// BOTTOM_LIMIT   479  a shot whose new y > BOTTOM_LIMIT is retired
// ALIEN_COOLDOWN 30   frames after an accepted alien shot before the next alien shot is accepted
// PORTS
// clk              in   1               system clock
// reset            in   1               asynchronous, active-high reset
// startOfFrame     in   1               1-cycle pulse per VGA frame
// player_fire_req  in   1               player requests a shot (level)
// player_x         in   11 signed       player top-left X
// player_y         in   11 signed       player top-left Y
// player_fire_ack  out  1               1-cycle pulse: player shot launched
// alien_fire_req   in   1               alien logic requests a shot (level)
// alien_x          in   11 signed       alien shot launch X
// alien_y          in   11 signed       alien shot launch Y
// alien_fire_ack   out  1               1-cycle pulse: alien shot launched
// hit              in   NUM_SLOTS       per-slot collision pulse; retires that slot
// active           out  NUM_SLOTS       slot live
// proj_x           out  NUM_SLOTS x 11  signed slot X, packed [NUM_SLOTS-1:0][10:0]
// proj_y           out  NUM_SLOTS x 11  signed slot Y, packed [NUM_SLOTS-1:0][10:0]
// busy             out  1               high while in UPDATE
// BEHAVIOUR
// - Reset: all outputs 0; FSM to IDLE; cooldown counter 0; slot index 0. Reset mid-flight drops all shots at once.
// - FSM: IDLE --startOfFrame--> UPDATE. UPDATE visits slot idx 0..NUM_SLOTS-1, one slot per cycle.
//   After the last slot it returns to IDLE. Update latency is NUM_SLOTS cycles; busy=1 throughout UPDATE.
// - startOfFrame in UPDATE is ignored; no second pass is queued.
// - Slot update, if active[idx]:
//   - slot 0: y -= PLAYER_SPEED; other slots: y += ALIEN_SPEED.
//   - Arithmetic is 12-bit signed, so there is no wrap.
//   - New y outside [TOP_LIMIT, BOTTOM_LIMIT]: active <= 0, proj_x/proj_y keep their last values.
//   - Otherwise proj_y <= new y truncated to 11 bits.
// - Cooldown: decrements by 1 per startOfFrame while >0, saturating at 0. Updated on the IDLE->UPDATE edge.
// - Fire acceptance happens only in IDLE; no ack is given in UPDATE. Requests are levels, and the requester
//   holds the request until ack. A request sampled high at edge N produces ack high for the cycle after edge N,
//   with the slot written at the same edge N.
//   - Player: accepted iff active[0]==0 and hit[0]==0 at that edge. Loads slot 0 with the launch offsets.
//   - Alien: accepted iff cooldown==0 and some slot 1..N-1 is free (active==0 and hit==0).
//     Uses the lowest-numbered free slot, loads alien_x/alien_y, and reloads cooldown=ALIEN_COOLDOWN.
//   - Player and alien requests can both be accepted in the same cycle; they use distinct slots.
//   - Pool full or cooldown>0: no ack, no state change.
// - hit[i]: active[i] <= 0 at the next edge in any FSM state. hit has priority over a same-cycle update or launch of slot i.
// - hit on an inactive slot: no effect.
// - Acks are single-cycle pulses. A held request with a free slot re-fires on the following IDLE cycle,
//   so requesters must drop the request after ack.
// TESTING
// 1. reset high mid-flight with 3 slots live -> all active/proj/ack =0 in the same cycle reset asserts.
// 2. player_x=100, player_y=440, fire_req 1 cycle in IDLE -> ack 1 cycle; active[0]=1, x=114, y=432.
//    3 frames later y=408.
// 3. player shot at y=4, startOfFrame -> new y=-4 < TOP_LIMIT -> active[0]=0 after its UPDATE cycle; busy high 4 cycles.
// 4. Alien reqs held high, cooldown 0 -> slots 1 and 2 fill 30 frames apart; slot 3 fills after another 30 frames.
//    Fourth request gets no ack while all alien slots are live.
// 5. hit[2] and alien request in the same IDLE cycle, slots 1 and 3 busy -> slot 2 retired, request not acked this cycle.
// 6. player+alien req same cycle, both eligible -> both acks pulse together; slot 0 and lowest free alien slot load.

Source files
------------

// File: rtl/projectile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : projectile_scheduler_if
// Description : Fire-request / slot-state bundle between the player and alien
//               control logic and the projectile scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface projectile_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                         startOfFrame;
  logic                         player_fire_req;
  logic signed [10:0]           player_x;
  logic signed [10:0]           player_y;
  logic                         player_fire_ack;
  logic                         alien_fire_req;
  logic signed [10:0]           alien_x;
  logic signed [10:0]           alien_y;
  logic                         alien_fire_ack;
  logic [NUM_SLOTS-1:0]         hit;
  logic [NUM_SLOTS-1:0]         active;
  logic [NUM_SLOTS-1:0][10:0]   proj_x;
  logic [NUM_SLOTS-1:0][10:0]   proj_y;
  logic                         busy;

  modport master (
    output startOfFrame, player_fire_req, player_x, player_y,
           alien_fire_req, alien_x, alien_y, hit,
    input  player_fire_ack, alien_fire_ack, active, proj_x, proj_y, busy
  );

  modport slave (
    input  startOfFrame, player_fire_req, player_x, player_y,
           alien_fire_req, alien_x, alien_y, hit,
    output player_fire_ack, alien_fire_ack, active, proj_x, proj_y, busy
  );
endinterface
`default_nettype wire

// File: rtl/projectile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : projectile_scheduler
// Description : Projectile slot pool: launches player/alien shots, moves every
//               live shot once per frame and retires them on hit or off-screen.
// Revision    : 1.0 - initial release
// ============================================================================
module projectile_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int PLAYER_SPEED   = 8,
  parameter int ALIEN_SPEED    = 4,
  parameter int PLAYER_X_OFS   = 14,
  parameter int PLAYER_Y_OFS   = 8,
  parameter int TOP_LIMIT      = 0,
  parameter int BOTTOM_LIMIT   = 479,
  parameter int ALIEN_COOLDOWN = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  projectile_scheduler_if.slave bus
);
  localparam int c_IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_CD_W  = (ALIEN_COOLDOWN > 1) ? $clog2(ALIEN_COOLDOWN + 1) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX     = c_IDX_W'(NUM_SLOTS - 1);
  localparam logic [c_CD_W-1:0]  c_CD_RELOAD    = c_CD_W'(ALIEN_COOLDOWN);
  localparam logic signed [11:0] c_PLAYER_SPEED = 12'(PLAYER_SPEED);
  localparam logic signed [11:0] c_ALIEN_SPEED  = 12'(ALIEN_SPEED);
  localparam logic signed [11:0] c_TOP          = 12'(TOP_LIMIT);
  localparam logic signed [11:0] c_BOTTOM       = 12'(BOTTOM_LIMIT);
  localparam logic signed [10:0] c_X_OFS        = 11'(PLAYER_X_OFS);
  localparam logic signed [10:0] c_Y_OFS        = 11'(PLAYER_Y_OFS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  state_t                       r_state;
  logic [c_IDX_W-1:0]           r_idx;
  logic [c_CD_W-1:0]            r_cooldown;
  logic [NUM_SLOTS-1:0]         r_active;
  logic [NUM_SLOTS-1:0][10:0]   r_x;
  logic [NUM_SLOTS-1:0][10:0]   r_y;
  logic                         r_player_ack;
  logic                         r_alien_ack;

  logic signed [10:0]           w_cur_y;
  logic signed [11:0]           w_cur_y_ext;
  logic signed [11:0]           w_new_y;
  logic                         w_off_screen;
  logic                         w_alien_free;
  logic [c_IDX_W-1:0]           w_alien_slot;
  logic                         w_player_accept;
  logic                         w_alien_accept;

  // 12-bit signed step so a shot crossing either screen edge is seen as out of range
  always_comb begin
    w_cur_y      = r_y[r_idx];
    w_cur_y_ext  = {w_cur_y[10], w_cur_y};
    w_new_y      = (r_idx == '0) ? (w_cur_y_ext - c_PLAYER_SPEED)
                                 : (w_cur_y_ext + c_ALIEN_SPEED);
    w_off_screen = (w_new_y < c_TOP) || (w_new_y > c_BOTTOM);
  end

  // Descending scan leaves the lowest-numbered free alien slot selected
  always_comb begin
    w_alien_free = 1'b0;
    w_alien_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 1; i--) begin
      if (!r_active[i] && !bus.hit[i]) begin
        w_alien_free = 1'b1;
        w_alien_slot = c_IDX_W'(i);
      end
    end
  end

  assign w_player_accept = (r_state == S_IDLE) && bus.player_fire_req &&
                           !r_active[0] && !bus.hit[0];
  assign w_alien_accept  = (r_state == S_IDLE) && bus.alien_fire_req &&
                           (r_cooldown == '0) && w_alien_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cooldown   <= '0;
      r_active     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_player_ack <= 1'b0;
      r_alien_ack  <= 1'b0;
    end else begin
      r_player_ack <= w_player_accept;
      r_alien_ack  <= w_alien_accept;

      case (r_state)
        S_IDLE: begin
          if (bus.startOfFrame) begin
            r_state <= S_UPDATE;
            r_idx   <= '0;
            if (r_cooldown != '0) begin
              r_cooldown <= r_cooldown - 1'b1;
            end
          end
        end
        S_UPDATE: begin
          if (r_idx == c_LAST_IDX) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
          if (r_active[r_idx] && !bus.hit[r_idx]) begin
            if (w_off_screen) begin
              r_active[r_idx] <= 1'b0;
            end else begin
              r_y[r_idx] <= w_new_y[10:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase

      if (w_player_accept) begin
        r_active[0] <= 1'b1;
        r_x[0]      <= bus.player_x + c_X_OFS;
        r_y[0]      <= bus.player_y - c_Y_OFS;
      end

      // Reload placed after the frame decrement so it wins on a shared edge
      if (w_alien_accept) begin
        r_active[w_alien_slot] <= 1'b1;
        r_x[w_alien_slot]      <= bus.alien_x;
        r_y[w_alien_slot]      <= bus.alien_y;
        r_cooldown             <= c_CD_RELOAD;
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.hit[i]) begin
          r_active[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.player_fire_ack = r_player_ack;
  assign bus.alien_fire_ack  = r_alien_ack;
  assign bus.active          = r_active;
  assign bus.proj_x          = r_x;
  assign bus.proj_y          = r_y;
  assign bus.busy            = (r_state == S_UPDATE);

endmodule
`default_nettype wire

// File: tb/tb_projectile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_projectile_scheduler
// Description : Scoreboard bench for projectile_scheduler with a slot-pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_projectile_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_alien_acks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  projectile_scheduler_if #(.NUM_SLOTS(N)) bus ();

  projectile_scheduler #(.NUM_SLOTS(N)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int slot;
    int x;
    int y;
  } ack_t;

  typedef struct {
    int                   cyc;
    logic [N-1:0]         act;
    logic [N-1:0][10:0]   px;
    logic [N-1:0][10:0]   py;
  } frame_t;

  ack_t   pq[$];
  ack_t   aq[$];
  frame_t fq[$];

  // Reference model: slot contents, cooldown and frame-pass progress
  bit m_act[N];
  int m_x[N];
  int m_y[N];
  int m_cd;
  int upd_left;

  bit p_hold, a_hold;
  int p_x, p_y, a_x, a_y;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int w11(input int v);
    logic [10:0] t;
    t = v[10:0];
    return int'($signed(t));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_cd = 0;
    upd_left = 0;
    p_hold = 1'b0;
    a_hold = 1'b0;
    pq.delete();
    aq.delete();
    fq.delete();
  endtask

  // One clock: drive inputs at the negedge, then advance the model to the next posedge
  task automatic step(input bit sof, input logic [N-1:0] hv);
    bit     idle_now, p_acc, a_acc, frame_done;
    int     a_slot, s, ny;
    ack_t   ea;
    frame_t ef;
    @(negedge clk);
    bus.startOfFrame    = sof;
    bus.hit             = hv;
    bus.player_fire_req = p_hold;
    bus.alien_fire_req  = a_hold;
    bus.player_x        = 11'(p_x);
    bus.player_y        = 11'(p_y);
    bus.alien_x         = 11'(a_x);
    bus.alien_y         = 11'(a_y);

    idle_now   = (upd_left == 0);
    frame_done = 1'b0;
    p_acc      = idle_now && p_hold && !m_act[0] && !hv[0];
    a_slot     = 0;
    for (int i = N - 1; i >= 1; i--) if (!m_act[i] && !hv[i]) a_slot = i;
    a_acc      = idle_now && a_hold && (m_cd == 0) && (a_slot != 0);

    if (idle_now && sof) begin
      upd_left = N;
      if (m_cd > 0) m_cd--;
    end else if (!idle_now) begin
      s = N - upd_left;
      if (m_act[s] && !hv[s]) begin
        ny = (s == 0) ? m_y[s] - 8 : m_y[s] + 4;
        if (ny < 0 || ny > 479) m_act[s] = 1'b0;
        else m_y[s] = ny;
      end
      upd_left--;
      frame_done = (upd_left == 0);
    end

    if (p_acc) begin
      m_act[0] = 1'b1;
      m_x[0]   = w11(p_x + 14);
      m_y[0]   = w11(p_y - 8);
      ea.cyc = cyc + 1; ea.slot = 0; ea.x = m_x[0]; ea.y = m_y[0];
      pq.push_back(ea);
      p_hold = 1'b0;
    end
    if (a_acc) begin
      m_act[a_slot] = 1'b1;
      m_x[a_slot]   = w11(a_x);
      m_y[a_slot]   = w11(a_y);
      m_cd          = 30;
      ea.cyc = cyc + 1; ea.slot = a_slot; ea.x = m_x[a_slot]; ea.y = m_y[a_slot];
      aq.push_back(ea);
      a_hold = 1'b0;
    end
    for (int i = 0; i < N; i++) if (hv[i]) m_act[i] = 1'b0;

    if (frame_done) begin
      ef.cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
        ef.act[i] = m_act[i];
        ef.px[i]  = 11'(m_x[i]);
        ef.py[i]  = 11'(m_y[i]);
      end
      fq.push_back(ef);
    end
  endtask

  task automatic frame(input bit extra_sof, input logic [N-1:0] hv_mid);
    int nb;
    nb = 0;
    step(1'b1, '0);
    for (int c = 0; c <= N; c++) begin
      step((c == 1) && extra_sof, (c == 2) ? hv_mid : '0);
      if (bus.busy) nb++;
    end
    chk("busy_cycles", nb, N);
    step(1'b0, '0);
  endtask

  // Monitor: pops expectations when the DUT presents an ack or finishes a frame pass
  bit     prev_busy = 1'b0;
  bit     mon_p, mon_a, mon_f, mon_fall;
  ack_t   mon_ea;
  frame_t mon_ef;

  always @(negedge clk) begin : monitor
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      mon_p = (pq.size() > 0) && (pq[0].cyc == cyc);
      if (bus.player_fire_ack || mon_p) begin
        chk("player_ack", bus.player_fire_ack, mon_p);
        if (mon_p) begin
          mon_ea = pq.pop_front();
          chk("player_launch_active", bus.active[0], 1);
          chk("player_launch_x", bus.proj_x[0], 11'(mon_ea.x));
          chk("player_launch_y", bus.proj_y[0], 11'(mon_ea.y));
        end
      end
      mon_a = (aq.size() > 0) && (aq[0].cyc == cyc);
      if (bus.alien_fire_ack) n_alien_acks++;
      if (bus.alien_fire_ack || mon_a) begin
        chk("alien_ack", bus.alien_fire_ack, mon_a);
        if (mon_a) begin
          mon_ea = aq.pop_front();
          chk("alien_launch_active", bus.active[mon_ea.slot], 1);
          chk("alien_launch_x", bus.proj_x[mon_ea.slot], 11'(mon_ea.x));
          chk("alien_launch_y", bus.proj_y[mon_ea.slot], 11'(mon_ea.y));
        end
      end
      mon_f    = (fq.size() > 0) && (fq[0].cyc == cyc);
      mon_fall = prev_busy && !bus.busy;
      if (mon_fall || mon_f) begin
        chk("frame_done", mon_fall, mon_f);
        if (mon_f) begin
          mon_ef = fq.pop_front();
          chk("frame_active", bus.active, mon_ef.act);
          for (int i = 0; i < N; i++) begin
            chk("frame_x", bus.proj_x[i], mon_ef.px[i]);
            chk("frame_y", bus.proj_y[i], mon_ef.py[i]);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    logic [N-1:0] hv;
    bus.startOfFrame = 1'b0; bus.hit = '0;
    bus.player_fire_req = 1'b0; bus.alien_fire_req = 1'b0;
    bus.player_x = '0; bus.player_y = '0; bus.alien_x = '0; bus.alien_y = '0;
    p_x = 0; p_y = 0; a_x = 0; a_y = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_active", bus.active, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.player_fire_ack, bus.alien_fire_ack}, 0);
    chk("rst_proj_x", bus.proj_x, 0);
    chk("rst_proj_y", bus.proj_y, 0);
    rst = 1'b0;

    // Player launch and flight; a stray startOfFrame mid-pass is ignored
    p_x = 100; p_y = 440; p_hold = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t2_ack", bus.player_fire_ack, 1);
    chk("t2_x", bus.proj_x[0], 114);
    chk("t2_y", bus.proj_y[0], 432);
    frame(1'b1, '0);
    frame(1'b0, '0);
    frame(1'b0, '0);
    chk("t2_y_3frames", bus.proj_y[0], 408);

    // Hit retires the player shot; a new shot at y=4 leaves the top
    step(1'b0, 4'b0001);
    step(1'b0, '0);
    chk("hit0_active", bus.active[0], 0);
    p_y = 12; p_hold = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t3_launch_y", bus.proj_y[0], 4);
    frame(1'b0, '0);
    chk("t3_retired", bus.active[0], 0);
    chk("t3_y_kept", bus.proj_y[0], 4);

    // Alien requests under cooldown until the pool is full
    a_x = 200; a_y = 20;
    for (int f = 0; f < 100; f++) begin
      a_hold = 1'b1;
      frame(1'b0, '0);
    end
    step(1'b0, '0);
    chk("t4_alien_acks", n_alien_acks, 3);
    chk("t4_pool_full", bus.active[3:1], 3'b111);

    // Hit on slot 2 blocks the same-cycle alien launch; it lands one cycle later
    step(1'b0, 4'b0100);
    step(1'b0, '0);
    chk("t5_slot2_retired", bus.active[2], 0);
    chk("t5_no_ack", bus.alien_fire_ack, 0);
    step(1'b0, '0);
    chk("t5_ack_next", bus.alien_fire_ack, 1);
    chk("t5_slot2_live", bus.active[2], 1);

    // Simultaneous player and alien launches
    step(1'b0, 4'b1010);
    for (int f = 0; f < 31; f++) frame(1'b0, '0);
    p_x = 300; p_y = 440; a_x = 50; a_y = 60;
    p_hold = 1'b1; a_hold = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t6_both_acks", {bus.player_fire_ack, bus.alien_fire_ack}, 2'b11);
    chk("t6_active", bus.active, 4'b0111);
    chk("t6_player_x", bus.proj_x[0], 314);
    chk("t6_alien_y", bus.proj_y[1], 60);

    // Asynchronous reset with three shots live clears everything immediately
    #2 rst = 1'b1;
    #1;
    chk("t1_active", bus.active, 0);
    chk("t1_acks", {bus.player_fire_ack, bus.alien_fire_ack}, 0);
    chk("t1_proj_x", bus.proj_x, 0);
    chk("t1_proj_y", bus.proj_y, 0);
    chk("t1_busy", bus.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (!p_hold && $urandom_range(0, 7) == 0) begin
        p_hold = 1'b1;
        p_x = $urandom_range(0, 639);
        p_y = $urandom_range(0, 479);
      end
      if (!a_hold && $urandom_range(0, 5) == 0) begin
        a_hold = 1'b1;
        a_x = $urandom_range(0, 639);
        a_y = $urandom_range(0, 479);
      end
      hv = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 24) == 0) hv[i] = 1'b1;
      step($urandom_range(0, 4) == 0, hv);
    end
    p_hold = 1'b0; a_hold = 1'b0;
    repeat (N + 3) step(1'b0, '0);
    chk("drain_player_q", pq.size(), 0);
    chk("drain_alien_q", aq.size(), 0);
    chk("drain_frame_q", fq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
